// File: rtl/ebpf_pkg.sv
// eBPF shift-issue shared definitions: instruction class/op encodings
// and the issue FSM state type.
package ebpf_pkg;

  localparam logic [2:0] BPF_ALU   = 3'h4;
  localparam logic [2:0] BPF_ALU64 = 3'h7;

  localparam logic [3:0] BPF_LSH  = 4'h6;
  localparam logic [3:0] BPF_RSH  = 4'h7;
  localparam logic [3:0] BPF_ARSH = 4'hC;

  localparam logic BPF_X = 1'b1;

  typedef enum logic [2:0] {
    FLUSH,
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/shift_operand_prep.sv
// Combinational decode of an eBPF shift instruction.
// In: opcode, dst_val, src_val, imm. Out: legal, alu64, left, arith,
// value (shifter operand), shift (masked count, upper bits zero).
module shift_operand_prep
  import ebpf_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [7:0]            opcode,
  input  logic [DATA_WIDTH-1:0] dst_val,
  input  logic [DATA_WIDTH-1:0] src_val,
  input  logic [31:0]           imm,
  output logic                  legal,
  output logic                  alu64,
  output logic                  left,
  output logic                  arith,
  output logic [DATA_WIDTH-1:0] value,
  output logic [DATA_WIDTH-1:0] shift
);

  logic        cls_ok;
  logic        op_ok;
  logic [5:0]  cnt_src;
  logic [31:0] lo;
  logic        unused_bits;

  // Only the low count bits matter, and sign extension of imm
  // never reaches them, so the full sign-extended source is not built.
  assign unused_bits = ^{src_val[DATA_WIDTH-1:6], imm[31:6]};

  always_comb begin
    alu64  = (opcode[2:0] == BPF_ALU64);
    cls_ok = (opcode[2:0] == BPF_ALU) | alu64;
    left   = 1'b0;
    arith  = 1'b0;
    op_ok  = 1'b0;
    unique case (1'b1)
      (opcode[7:4] == BPF_LSH): begin
        left  = 1'b1;
        op_ok = 1'b1;
      end
      (opcode[7:4] == BPF_RSH): begin
        op_ok = 1'b1;
      end
      (opcode[7:4] == BPF_ARSH): begin
        arith = 1'b1;
        op_ok = 1'b1;
      end
      default: begin
        op_ok = 1'b0;
      end
    endcase
    legal = cls_ok & op_ok;

    cnt_src = (opcode[3] == BPF_X) ? src_val[5:0] : imm[5:0];
    shift = '0;
    shift[4:0] = cnt_src[4:0];
    shift[5]   = alu64 & cnt_src[5];

    lo = dst_val[31:0];
    if (alu64) begin
      value = dst_val;
    end else begin
      value = {{(DATA_WIDTH-32){arith & lo[31]}}, lo};
    end
  end

endmodule

// File: rtl/alu_shift_issue.sv
// eBPF LSH/RSH/ARSH issue stage: accepts an op, drives the shifter
// stb/ack handshake, returns the zero-extended result or an error.
// Ports: clk, rst (sync, active high); in_stb/in_busy request side;
// opcode/dst_val/src_val/imm operands; out_valid/out_res/out_err result;
// sh_* shifter interface (sh_out/sh_ack back from the shifter).
// Optional macro SHIFT_TIMEOUT_EN: watchdog of TIMEOUT_CYCLES on sh_ack.
module alu_shift_issue
  import ebpf_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_stb,
  output logic                  in_busy,
  input  logic [7:0]            opcode,
  input  logic [DATA_WIDTH-1:0] dst_val,
  input  logic [DATA_WIDTH-1:0] src_val,
  input  logic [31:0]           imm,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_res,
  output logic                  out_err,
  output logic                  sh_stb,
  output logic                  sh_arith,
  output logic                  sh_left,
  output logic [DATA_WIDTH-1:0] sh_value,
  output logic [DATA_WIDTH-1:0] sh_shift,
  input  logic [DATA_WIDTH-1:0] sh_out,
  input  logic                  sh_ack
);

  state_t state;
  state_t state_n;

  logic                  flush_cnt;
  logic                  alu64_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] res_q;

  logic                  p_legal;
  logic                  p_alu64;
  logic                  p_left;
  logic                  p_arith;
  logic [DATA_WIDTH-1:0] p_value;
  logic [DATA_WIDTH-1:0] p_shift;

  logic accept;
  logic timeout;
  logic to_q;

`ifdef SHIFT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;
  assign timeout = (state == WAIT) & ~sh_ack
                 & (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  shift_operand_prep #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_prep (
    .opcode (opcode),
    .dst_val(dst_val),
    .src_val(src_val),
    .imm    (imm),
    .legal  (p_legal),
    .alu64  (p_alu64),
    .left   (p_left),
    .arith  (p_arith),
    .value  (p_value),
    .shift  (p_shift)
  );

  assign accept = (state == IDLE) & in_stb;

  always_comb begin
    state_n = state;
    sh_stb  = 1'b0;
    in_busy = 1'b1;
    unique case (state)
      FLUSH: begin
        if (flush_cnt) state_n = IDLE;
      end
      IDLE: begin
        in_busy = 1'b0;
        if (in_stb) state_n = p_legal ? ISSUE : DONE;
      end
      ISSUE: begin
        sh_stb  = 1'b1;
        state_n = WAIT;
      end
      WAIT: begin
        if (sh_ack || timeout) state_n = DONE;
      end
      DONE: begin
        // a timed-out shifter may still be busy, so drain it again
        state_n = to_q ? FLUSH : IDLE;
      end
      default: begin
        state_n = FLUSH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FLUSH;
      flush_cnt <= 1'b0;
      alu64_q   <= 1'b0;
      err_q     <= 1'b0;
      res_q     <= '0;
      to_q      <= 1'b0;
      out_valid <= 1'b0;
      out_res   <= '0;
      out_err   <= 1'b0;
      sh_arith  <= 1'b0;
      sh_left   <= 1'b0;
      sh_value  <= '0;
      sh_shift  <= '0;
    end else begin
      state     <= state_n;
      flush_cnt <= (state == FLUSH) & ~flush_cnt;
      out_valid <= (state == DONE);
      if (state == DONE) begin
        out_res <= res_q;
        out_err <= err_q;
      end
      if (accept) begin
        alu64_q <= p_alu64;
        err_q   <= ~p_legal;
        res_q   <= '0;
        to_q    <= 1'b0;
        if (p_legal) begin
          sh_arith <= p_arith;
          sh_left  <= p_left;
          sh_value <= p_value;
          sh_shift <= p_shift;
        end
      end
      if (state == WAIT && sh_ack) begin
        res_q <= alu64_q ? sh_out
                         : {{(DATA_WIDTH-32){1'b0}}, sh_out[31:0]};
      end else if (timeout) begin
        res_q <= '0;
        err_q <= 1'b1;
        to_q  <= 1'b1;
      end
    end
  end

`ifdef SHIFT_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_shift_issue.sv
// Scoreboard bench for alu_shift_issue: random and directed eBPF shifts
// against an instruction-level model, with a behavioural shifter.
module tb_alu_shift_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_stb = 1'b0;
  logic        in_busy;
  logic [7:0]  opcode = '0;
  logic [63:0] dst_val = '0;
  logic [63:0] src_val = '0;
  logic [31:0] imm = '0;
  logic        out_valid;
  logic [63:0] out_res;
  logic        out_err;
  logic        sh_stb;
  logic        sh_arith;
  logic        sh_left;
  logic [63:0] sh_value;
  logic [63:0] sh_shift;
  logic [63:0] sh_out = '0;
  logic        sh_ack = 1'b0;

  alu_shift_issue #(.DATA_WIDTH(64), .TIMEOUT_CYCLES(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_stb   (in_stb),
    .in_busy  (in_busy),
    .opcode   (opcode),
    .dst_val  (dst_val),
    .src_val  (src_val),
    .imm      (imm),
    .out_valid(out_valid),
    .out_res  (out_res),
    .out_err  (out_err),
    .sh_stb   (sh_stb),
    .sh_arith (sh_arith),
    .sh_left  (sh_left),
    .sh_value (sh_value),
    .sh_shift (sh_shift),
    .sh_out   (sh_out),
    .sh_ack   (sh_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    logic        err;
    longint      cyc;
  } exp_t;

  typedef struct {
    logic [63:0] value;
    logic [63:0] shift;
    logic        left;
    logic        arith;
  } sh_t;

  exp_t exp_q[$];
  sh_t  sh_q[$];

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;

  int hold_ack  = 0;
  int ack_delay = 0;
  int spur      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // eBPF semantics, computed straight from the instruction definition.
  function automatic void ref_op(input logic [7:0] op,
                                 input logic [63:0] dst,
                                 input logic [63:0] src,
                                 input logic [31:0] im,
                                 output logic legal,
                                 output logic [63:0] res,
                                 output sh_t sh);
    logic [63:0] s;
    logic [31:0] d32;
    logic signed [63:0] t64;
    logic signed [31:0] t32;
    int n;
    bit a64, a32;
    a64 = (op[2:0] == 3'h7);
    a32 = (op[2:0] == 3'h4);
    legal = (a64 || a32) &&
            (op[7:4] == 4'h6 || op[7:4] == 4'h7 || op[7:4] == 4'hC);
    s = op[3] ? src : {{32{im[31]}}, im};
    res = '0;
    sh.value = '0;
    sh.shift = '0;
    sh.left  = (op[7:4] == 4'h6);
    sh.arith = (op[7:4] == 4'hC);
    if (!legal) return;
    if (a64) begin
      n = int'(s % 64);
      t64 = $signed(dst) >>> n;
      if (sh.left) res = dst << n;
      else if (sh.arith) res = t64;
      else res = dst >> n;
      sh.value = dst;
    end else begin
      n = int'(s % 32);
      d32 = dst[31:0];
      t32 = $signed(d32) >>> n;
      if (sh.left) res = {32'h0, d32 << n};
      else if (sh.arith) res = {32'h0, t32};
      else res = {32'h0, d32 >> n};
      sh.value = sh.arith ? {{32{d32[31]}}, d32} : {32'h0, d32};
    end
    sh.shift = 64'(n);
  endfunction

  function automatic logic [63:0] shifter(input logic [63:0] v,
                                          input logic [63:0] k,
                                          input logic l,
                                          input logic a);
    logic signed [63:0] t;
    t = $signed(v) >>> k;
    if (l) return v << k;
    if (a) return t;
    return v >> k;
  endfunction

  // Behavioural shifter: ack after ack_delay extra cycles, result taken
  // from the operands present at ack time.
  int pend = 0;
  int dcnt = 0;
  always @(posedge clk) begin
    sh_ack <= 1'b0;
    if (sh_stb && hold_ack == 0) begin
      if (ack_delay == 0) begin
        sh_ack <= 1'b1;
        sh_out <= shifter(sh_value, sh_shift, sh_left, sh_arith);
      end else begin
        pend = 1;
        dcnt = ack_delay;
      end
    end else if (pend != 0) begin
      dcnt--;
      if (dcnt == 0) begin
        pend = 0;
        sh_ack <= 1'b1;
        sh_out <= shifter(sh_value, sh_shift, sh_left, sh_arith);
      end
    end else if (spur != 0 && !sh_stb) begin
      spur = 0;
      sh_ack <= 1'b1;
      sh_out <= {$urandom, $urandom};
    end
  end

  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got res %h err %b",
                 out_res, out_err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_res", out_res, e.res);
        chk("out_err", 64'(out_err), 64'(e.err));
        chk("latency_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (sh_stb) begin
      if (sh_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sh_stb: got value %h shift %h",
                 sh_value, sh_shift);
      end else begin
        sh_t s;
        s = sh_q.pop_front();
        chk("sh_value", sh_value, s.value);
        chk("sh_shift", sh_shift, s.shift);
        chk("sh_left", 64'(sh_left), 64'(s.left));
        chk("sh_arith", 64'(sh_arith), 64'(s.arith));
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!in_busy) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_idle: in_busy stuck high, got 1 want 0");
  endtask

  task automatic issue(input logic [7:0] op, input logic [63:0] dst,
                       input logic [63:0] src, input logic [31:0] im,
                       input int delay, input int lat_ovr,
                       input bit hold_stb, input bit abort,
                       input bit spurious);
    logic legal;
    logic [63:0] res;
    sh_t sh;
    int lat;
    wait_idle();
    ack_delay = delay;
    if (spurious) spur = 1;
    ref_op(op, dst, src, im, legal, res, sh);
    lat = legal ? 3 + delay : 1;
    if (lat_ovr > 0) begin
      lat = lat_ovr;
      res = '0;
      legal = 1'b0;
    end
    if (sh.left || sh.arith || op[7:4] == 4'h7)
      if ((op[2:0] == 3'h4 || op[2:0] == 3'h7) &&
          (op[7:4] == 4'h6 || op[7:4] == 4'h7 || op[7:4] == 4'hC))
        sh_q.push_back(sh);
    if (!abort) exp_q.push_back('{res, !legal, cyc + 1 + lat});
    opcode  = op;
    dst_val = dst;
    src_val = src;
    imm     = im;
    in_stb  = 1'b1;
    @(posedge clk);
    if (hold_stb) @(posedge clk);
    #1;
    in_stb = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_busy", 64'(in_busy), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_res", out_res, 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    chk("rst_sh_stb", 64'(sh_stb), 64'd0);
    chk("rst_sh_value", sh_value, 64'd0);
    chk("rst_sh_shift", sh_shift, 64'd0);
    rst = 1'b0;

    issue(8'h6F, 64'h1, 64'h43, 32'h0, 0, 0, 0, 0, 0);
    issue(8'hC4, 64'hFFFFFFFF_80000000, 64'h0, 32'd4, 0, 0, 0, 0, 0);
    issue(8'h74, 64'hDEADBEEF_80000000, 64'h0, 32'd36, 0, 0, 0, 0, 0);
    issue(8'hCF, 64'h80000000_00000000, 64'd63, 32'h0, 0, 0, 0, 0, 0);
    issue(8'h0F, 64'h1234, 64'h5, 32'h0, 0, 0, 1, 0, 0);
    issue(8'h64, 64'hFFFFFFFF_12345678, 64'h0, 32'h0, 0, 0, 0, 0, 0);
    issue(8'h67, 64'h1, 64'h0, 32'hFFFFFFFF, 2, 0, 0, 0, 0);
    issue(8'h7C, 64'hFFFFFFFF_F0000000, 64'h3F, 32'h0, 1, 0, 0, 0, 1);

    for (int i = 0; i < 60; i++) begin
      logic [7:0] op;
      int r;
      r = $urandom_range(0, 9);
      op[2:0] = (r < 4) ? 3'h4 : (r < 8) ? 3'h7 : 3'($urandom);
      r = $urandom_range(0, 9);
      op[7:4] = (r < 3) ? 4'h6 : (r < 6) ? 4'h7 : (r < 9) ? 4'hC
              : 4'($urandom);
      op[3] = 1'($urandom);
      issue(op, {$urandom, $urandom}, {$urandom, $urandom}, $urandom,
            $urandom_range(0, 3), 0, 0, 0, ($urandom_range(0, 3) == 0));
    end

    hold_ack = 1;
    issue(8'h6F, 64'h5, 64'h2, 32'h0, 0, 0, 0, 1, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy_flush1", 64'(in_busy), 64'd1);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("abort_busy_flush2", 64'(in_busy), 64'd1);
    @(negedge clk);
    chk("abort_busy_idle", 64'(in_busy), 64'd0);
    hold_ack = 0;
    issue(8'h67, 64'h3, 64'h0, 32'd10, 0, 0, 0, 0, 0);

`ifdef SHIFT_TIMEOUT_EN
    hold_ack = 1;
    issue(8'h77, 64'hFF00, 64'h4, 32'h0, 0, 18, 0, 0, 0);
    wait_idle();
    hold_ack = 0;
    issue(8'h6F, 64'h1, 64'd5, 32'h0, 0, 0, 0, 0, 0);
`endif

    wait_idle();
    repeat (6) @(negedge clk);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("sh_q_drained", 64'(sh_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_shift_issue.md
Name: alu_shift_issue

Overview:
- Upstream issue/writeback stage for the eBPF shift unit.
- Decodes eBPF LSH/RSH/ARSH instructions for both ALU (32-bit) and ALU64 classes, selects the shift source (register or immediate), masks the shift count and prepares the 32-bit operand.
- Drives the shifter's stb/ack handshake, then returns the zero-extended result to the execute pipeline.

Parameters:
- DATA_WIDTH, 64, operand/result width
- TIMEOUT_CYCLES, 16, watchdog limit (only with SHIFT_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_stb  in  1  request strobe; sampled only when in_busy=0
- in_busy  out  1  high from acceptance until out_valid has been presented
- opcode  in  8  eBPF opcode byte
- dst_val  in  DATA_WIDTH  destination register value
- src_val  in  DATA_WIDTH  source register value
- imm  in  32  instruction immediate
- out_valid  out  1  one-cycle result pulse
- out_res  out  DATA_WIDTH  result; held until next out_valid
- out_err  out  1  qualifies out_valid: illegal opcode or timeout
- sh_stb  out  1  shifter strobe
- sh_arith  out  1  arithmetic right shift
- sh_left  out  1  left shift
- sh_value  out  DATA_WIDTH  shifter operand
- sh_shift  out  DATA_WIDTH  shift count
- sh_out  in  DATA_WIDTH  shifter result
- sh_ack  in  1  shifter done pulse

Behaviour:
- Reset:
  - in_busy=1, out_valid=0, out_res=0, out_err=0, sh_stb=0, sh_* operands=0.
  - State goes to FLUSH.
- FSM states: FLUSH, IDLE, ISSUE, WAIT, DONE.
  - FLUSH: 2 cycles with sh_stb=0, so any shifter op in flight before reset drains (the shifter has no reset). Then IDLE with in_busy=0.
  - IDLE: in_stb=1 at an edge → operands registered, in_busy=1.
    - Legal op → ISSUE.
    - Illegal op → DONE with out_err=1, out_res=0; sh_stb is never asserted.
  - ISSUE: sh_stb=1 for exactly one cycle → WAIT.
  - WAIT: sh_stb=0. On sh_ack=1 → capture the result, go to DONE.
  - DONE: out_valid=1 for one cycle → IDLE, in_busy=0.
- Legal opcodes:
  - class in opcode[2:0]: 0x4 = ALU32, 0x7 = ALU64.
  - op in opcode[7:4]: 0x6 = LSH, 0x7 = RSH, 0xC = ARSH.
  - opcode[3]=1 selects src_val, 0 selects imm sign-extended to 64 bits.
  - Everything else is illegal.
- Shift count: source masked to [5:0] for ALU64 and [4:0] for ALU32; upper bits zero.
- sh_value:
  - ALU64: dst_val.
  - ALU32 ARSH: dst_val[31:0] sign-extended.
  - ALU32 LSH/RSH: dst_val[31:0] zero-extended.
- sh_left=1 for LSH. sh_arith=1 for ARSH.
- Result: ALU64 takes sh_out unchanged; ALU32 takes {32'b0, sh_out[31:0]}.
- sh_value, sh_shift, sh_arith and sh_left stay stable from ISSUE until sh_ack.
- Latency (acceptance edge = T):
  - legal: sh_stb high after T, sh_ack after T+2, out_valid after T+3.
  - illegal: out_valid after T+1.
- in_stb while in_busy=1: ignored; nothing is queued.
- sh_ack outside WAIT: ignored.
- rst in any state: abort, apply reset values, pass through FLUSH; no out_valid for the aborted op.
- Shift count 0: value is passed through (ALU32 still zero-extends).

Optional Feature:
- Macro SHIFT_TIMEOUT_EN.
- When defined: a counter clears on entry to WAIT. If sh_ack is absent for TIMEOUT_CYCLES cycles → DONE with out_err=1, out_res=0, then FLUSH before IDLE.
- When undefined: no counter; WAIT waits indefinitely.

Decomposition:
- Package ebpf_pkg holds:
  - class constants BPF_ALU=3'h4, BPF_ALU64=3'h7.
  - op constants BPF_LSH=4'h6, BPF_RSH=4'h7, BPF_ARSH=4'hC.
  - source bit BPF_X=1.
  - state enum typedef.
- Sub-module shift_operand_prep: combinational decode, legality check, count masking and sign/zero extension. The FSM stays in alu_shift_issue.

Test Plan:
- ALU64 LSH X (opcode 0x6F): dst=0x1, src=0x43 → shift 3, out_res=0x8, out_err=0, out_valid 3 cycles after accept.
- ALU32 ARSH K (opcode 0xC4): dst=0xFFFFFFFF_80000000, imm=4 → sh_value=0xFFFFFFFF_80000000, out_res=0x00000000_F8000000.
- ALU32 RSH K (opcode 0x74): dst=0xDEADBEEF_80000000, imm=36 → shift 4, out_res=0x00000000_08000000.
- ALU64 ARSH X (opcode 0xCF): dst=0x80000000_00000000, src=63 → out_res=0xFFFFFFFF_FFFFFFFF.
- Illegal opcode 0x0F: → sh_stb never high, out_valid with out_err=1 and out_res=0 one cycle after accept; a second in_stb while busy is dropped.
- rst pulsed during WAIT:
  - → no out_valid for the aborted op.
  - → in_busy stays high for 2 FLUSH cycles.
  - → a following LSH completes correctly.
  - With SHIFT_TIMEOUT_EN, holding sh_ack low → out_err after 16 cycles.
